idecode_fwd: RTL and testbench
==============================

Name: idecode_fwd

Overview:
- Parametrised successor to the decode stage; sits between IF and EX.
- Decodes one instruction per cycle and reads rd/rs from the register file.
- Resolves RAW hazards with NFWD forwarding ports instead of always stalling.
- A 2-entry output skid buffer means stall_i never reaches stall_o combinationally. A saturating hazard-stall counter is exposed for profiling.

Parameters:
WORD, 32, data word width
ADDR, 32, address width (ADDR <= WORD)
W_RD, 4, register-name width (rd and rs)
NFWD, 2, number of forwarding ports; index 0 is the youngest producer
CNTW, 16, width of the hazard-stall counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
v_i  in  1  IF instruction valid
stall_o  out  1  back-pressure to IF
inst_i  in  WORD  instruction
origaddr_i  in  ADDR  instruction address
v_o  out  1  EX-side valid (head entry)
stall_i  in  1  back-pressure from EX
src_o, dest_o  out  WORD  source operand / rd operand
wb_o  out  1  writeback required
wb_rd_name_o  out  W_RD  writeback register
dopc_o  out  W_DOPC  decoded opcode
opc_o  out  W_OPC  raw opcode
origaddr_o  out  ADDR  instruction address
cc_o  out  W_CC  condition code (low bits of rd)
data_addr_o  out  ADDR  rs + signed imm
rd_reserve_o  out  1  reserve rd in the register file
rd_name_o, rs_name_o  out  W_RD  register-file read names (combinational from inst_i)
rd_data_i, rs_data_i  in  WORD  register-file read data
rd_reserved_i, rs_reserved_i  in  1  register-file scoreboard bits
fwd_v_i  in  NFWD  forwarding valid
fwd_name_i  in  NFWD*W_RD  forwarded register names
fwd_data_i  in  NFWD*WORD  forwarded data
hz_cnt_o  out  CNTW  hazard-stall cycles, saturating

Behaviour:
- Field extraction, decode_ope, expand_imm and wb_required are the shared codebase definitions.
- Forward hit for register X: the lowest-index port k with fwd_v_i[k] & fwd_name_i[k]==X.
- rd operand: if rd_reserved_i, take the forward hit; otherwise rd_data_i.
- rs operand: same rule using rs_reserved_i and rs_data_i.
- Hazard, rd side: rd_reserved_i with no forward hit.
- Hazard, rs side: ~immf & rs_reserved_i with no forward hit.
- src = immf ? expand_imm(opc, imm) : rs operand.
- data_addr = rs operand[ADDR-1:0] + sign-extended imm, wrapping modulo 2^ADDR.
- The data_addr rule applies even when immf=1.
- Buffer: head register H drives all EX outputs; skid register S holds overflow.
- stall_o = v_i & (S.v | hazard). It depends only on S.v, not on stall_i.
- accept = v_i & ~S.v & ~hazard.
- rd_reserve_o = accept & wb. It is asserted in the same cycle the entry is captured.
- Capture rules, per cycle:
  - ~stall_i & S.v: H<=S; S.v<=0. No accept this cycle, since stall_o=1.
  - ~stall_i & ~S.v: H.v<=accept; H fields<=new entry.
  - stall_i & ~H.v: H<=new entry with H.v<=accept.
  - stall_i & H.v & accept: S<=new entry; S.v<=1.
  - stall_i & H.v & ~accept: hold.
- An entry is never dropped or duplicated. The order H before S is always preserved.
- H fields are don't-care while H.v=0; they may update freely.
- hz_cnt_o increments on every cycle with v_i & hazard & ~S.v. It holds at 2^CNTW-1.
- Reset: H.v=S.v=0, all H/S fields 0, hz_cnt_o=0.
  - After reset: v_o=0, stall_o=0 if v_i=0, rd_reserve_o follows accept.
  - Reset mid-stall discards both entries.
- Simultaneous hits on several ports: the lowest index wins. The register-file data is ignored whenever the register is reserved.

Decomposition:
- Shared package (params.vh): WORD/ADDR defaults, field MSB/LSB macros, W_OPC, W_DOPC, W_CC, W_RD.
- Shared decode functions: decode_ope, expand_imm, wb_required.
- Sub-module fwd_mux (NFWD, WORD, W_RD): priority name match. Outputs hit and data. Instantiated twice, once for rd and once for rs.

Test Plan:
- No hazards, stall_i=0, 4 back-to-back ADD reg-reg → v_o high each following cycle, origaddr_o 0,4,8,12, stall_o never 1.
- rs_reserved_i=1 for r3, fwd port1 = (r3, 0x55), immf=0 → no stall, src_o=0x55 next cycle.
- The same case with port0 also = (r3, 0xAA) → src_o=0xAA.
- rs reserved, no forward hit, held 3 cycles → stall_o=1 for 3 cycles, hz_cnt_o=3, rd_reserve_o=0 until the hazard clears.
- H valid, stall_i=1, new instruction arrives → it goes to S; stall_o=1 the next cycle.
- Then drop stall_i → H shows the old entry, then S's entry, then new accepts resume. No loss or duplication.
- rs_data_i=0xFFFFFFF0, imm=+0x20 → data_addr_o=0x00000010 (wrap).
- CNTW=2 with a 6-cycle hazard → hz_cnt_o saturates at 3.
- Assert rst low while S.v=1 → v_o=0 and hz_cnt_o=0 asynchronously.
- After release, the first instruction passes normally.

Source files
------------

// File: rtl/idecode_fwd_pkg.sv
// Shared decode definitions for the idecode_fwd stage.
// Holds the instruction field layout, the opcode and decoded-opcode enums, and
// the common decode helpers decode_ope, expand_imm and wb_required.
// Instruction layout: [31:28] opc | [27:24] rd | [23:20] rs | [19] immf | [18:16] zero | [15:0] imm
package idecode_fwd_pkg;

  localparam int WORD_DEF = 32;
  localparam int ADDR_DEF = 32;
  localparam int W_RD_DEF = 4;
  localparam int W_OPC    = 4;
  localparam int W_DOPC   = 3;
  localparam int W_CC     = 3;
  localparam int W_IMM    = 16;

  localparam int OPC_LSB  = 28;
  localparam int RD_LSB   = 24;
  localparam int RS_LSB   = 20;
  localparam int IMMF_BIT = 19;
  localparam int IMM_LSB  = 0;

  typedef enum logic [W_OPC-1:0] {
    OPC_NOP = 4'd0,
    OPC_ADD = 4'd1,
    OPC_SUB = 4'd2,
    OPC_AND = 4'd3,
    OPC_OR  = 4'd4,
    OPC_LUI = 4'd5,
    OPC_LD  = 4'd6,
    OPC_ST  = 4'd7,
    OPC_BR  = 4'd8
  } opc_e;

  typedef enum logic [W_DOPC-1:0] {
    DOP_NOP = 3'd0,
    DOP_ALU = 3'd1,
    DOP_LUI = 3'd2,
    DOP_LD  = 3'd3,
    DOP_ST  = 3'd4,
    DOP_BR  = 3'd5
  } dopc_e;

  function automatic dopc_e decode_ope(input logic [W_OPC-1:0] opc);
    dopc_e d;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: d = DOP_ALU;
      OPC_LUI: d = DOP_LUI;
      OPC_LD:  d = DOP_LD;
      OPC_ST:  d = DOP_ST;
      OPC_BR:  d = DOP_BR;
      default: d = DOP_NOP;
    endcase
    return d;
  endfunction

  // LUI places the immediate in the upper half; everything else sign-extends.
  function automatic logic [31:0] expand_imm(input logic [W_OPC-1:0] opc,
                                             input logic [W_IMM-1:0] imm);
    if (opc == OPC_LUI) return {imm, 16'h0000};
    return {{(32-W_IMM){imm[W_IMM-1]}}, imm};
  endfunction

  function automatic logic wb_required(input logic [W_OPC-1:0] opc);
    dopc_e d;
    d = decode_ope(opc);
    return (d == DOP_ALU) || (d == DOP_LUI) || (d == DOP_LD);
  endfunction

endpackage

// File: rtl/idecode_fwd_if.sv
// Bundle of all IF-side, EX-side, register-file and forwarding signals of the
// decode stage. slave is the decode stage itself; master is its surroundings.
interface idecode_fwd_if #(
  parameter int WORD = 32,
  parameter int ADDR = 32,
  parameter int W_RD = 4,
  parameter int NFWD = 2,
  parameter int CNTW = 16
);
  import idecode_fwd_pkg::*;

  logic                   v_i;
  logic                   stall_o;
  logic [WORD-1:0]        inst_i;
  logic [ADDR-1:0]        origaddr_i;
  logic                   v_o;
  logic                   stall_i;
  logic [WORD-1:0]        src_o;
  logic [WORD-1:0]        dest_o;
  logic                   wb_o;
  logic [W_RD-1:0]        wb_rd_name_o;
  logic [W_DOPC-1:0]      dopc_o;
  logic [W_OPC-1:0]       opc_o;
  logic [ADDR-1:0]        origaddr_o;
  logic [W_CC-1:0]        cc_o;
  logic [ADDR-1:0]        data_addr_o;
  logic                   rd_reserve_o;
  logic [W_RD-1:0]        rd_name_o;
  logic [W_RD-1:0]        rs_name_o;
  logic [WORD-1:0]        rd_data_i;
  logic [WORD-1:0]        rs_data_i;
  logic                   rd_reserved_i;
  logic                   rs_reserved_i;
  logic [NFWD-1:0]        fwd_v_i;
  logic [NFWD*W_RD-1:0]   fwd_name_i;
  logic [NFWD*WORD-1:0]   fwd_data_i;
  logic [CNTW-1:0]        hz_cnt_o;

  modport slave (
    input  v_i, inst_i, origaddr_i, stall_i, rd_data_i, rs_data_i,
           rd_reserved_i, rs_reserved_i, fwd_v_i, fwd_name_i, fwd_data_i,
    output stall_o, v_o, src_o, dest_o, wb_o, wb_rd_name_o, dopc_o, opc_o,
           origaddr_o, cc_o, data_addr_o, rd_reserve_o, rd_name_o, rs_name_o,
           hz_cnt_o
  );

  modport master (
    output v_i, inst_i, origaddr_i, stall_i, rd_data_i, rs_data_i,
           rd_reserved_i, rs_reserved_i, fwd_v_i, fwd_name_i, fwd_data_i,
    input  stall_o, v_o, src_o, dest_o, wb_o, wb_rd_name_o, dopc_o, opc_o,
           origaddr_o, cc_o, data_addr_o, rd_reserve_o, rd_name_o, rs_name_o,
           hz_cnt_o
  );

endinterface

// File: rtl/idecode_fwd_fwd_mux.sv
// Priority forwarding match for one register name.
// Ports: name (register looked up), fwd_v/fwd_name/fwd_data (flattened
// forwarding ports, port 0 youngest), hit (some port matched), data (value of
// the lowest-index matching port, 0 when no hit).
module idecode_fwd_fwd_mux #(
  parameter int NFWD = 2,
  parameter int WORD = 32,
  parameter int W_RD = 4
) (
  input  logic [W_RD-1:0]      name,
  input  logic [NFWD-1:0]      fwd_v,
  input  logic [NFWD*W_RD-1:0] fwd_name,
  input  logic [NFWD*WORD-1:0] fwd_data,
  output logic                 hit,
  output logic [WORD-1:0]      data
);

  // Scan from the oldest port down so the youngest match is written last.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_v[k] && (fwd_name[k*W_RD +: W_RD] == name)) begin
        hit  = 1'b1;
        data = fwd_data[k*WORD +: WORD];
      end
    end
  end

endmodule

// File: rtl/idecode_fwd.sv
// Decode stage with operand forwarding and a 2-entry output skid buffer.
// Ports: clk, rst (async, active-low), bus (idecode_fwd_if.slave): IF side
// v_i/inst_i/origaddr_i/stall_o, EX side v_o/stall_i and decoded fields,
// register-file read names/data/reserved bits, forwarding ports, hz_cnt_o.
module idecode_fwd
  import idecode_fwd_pkg::*;
#(
  parameter int WORD = 32,
  parameter int ADDR = 32,
  parameter int W_RD = 4,
  parameter int NFWD = 2,
  parameter int CNTW = 16
) (
  input logic        clk,
  input logic        rst,
  idecode_fwd_if.slave bus
);

  typedef struct packed {
    logic [WORD-1:0]   src;
    logic [WORD-1:0]   dest;
    logic              wb;
    logic [W_RD-1:0]   wb_rd_name;
    logic [W_DOPC-1:0] dopc;
    logic [W_OPC-1:0]  opc;
    logic [ADDR-1:0]   origaddr;
    logic [W_CC-1:0]   cc;
    logic [ADDR-1:0]   data_addr;
  } entry_t;

  logic [W_OPC-1:0] opc;
  logic [W_RD-1:0]  rd;
  logic [W_RD-1:0]  rs;
  logic             immf;
  logic [W_IMM-1:0] imm;

  logic             rd_hit, rs_hit;
  logic [WORD-1:0]  rd_fwd, rs_fwd;
  logic [WORD-1:0]  rd_op, rs_op;
  logic             hazard, accept;
  entry_t           nxt, h, s;
  logic             h_v, s_v;
  logic [CNTW-1:0]  hz_cnt;

  assign opc  = bus.inst_i[OPC_LSB +: W_OPC];
  assign rd   = bus.inst_i[RD_LSB +: W_RD];
  assign rs   = bus.inst_i[RS_LSB +: W_RD];
  assign immf = bus.inst_i[IMMF_BIT];
  assign imm  = bus.inst_i[IMM_LSB +: W_IMM];

  assign bus.rd_name_o = rd;
  assign bus.rs_name_o = rs;

  idecode_fwd_fwd_mux #(.NFWD(NFWD), .WORD(WORD), .W_RD(W_RD)) u_fwd_rd (
    .name(rd), .fwd_v(bus.fwd_v_i), .fwd_name(bus.fwd_name_i),
    .fwd_data(bus.fwd_data_i), .hit(rd_hit), .data(rd_fwd)
  );

  idecode_fwd_fwd_mux #(.NFWD(NFWD), .WORD(WORD), .W_RD(W_RD)) u_fwd_rs (
    .name(rs), .fwd_v(bus.fwd_v_i), .fwd_name(bus.fwd_name_i),
    .fwd_data(bus.fwd_data_i), .hit(rs_hit), .data(rs_fwd)
  );

  // A reserved register never uses the register-file value, hit or not.
  assign rd_op = bus.rd_reserved_i ? rd_fwd : bus.rd_data_i;
  assign rs_op = bus.rs_reserved_i ? rs_fwd : bus.rs_data_i;

  assign hazard = (bus.rd_reserved_i & ~rd_hit) |
                  (~immf & bus.rs_reserved_i & ~rs_hit);
  assign accept = bus.v_i & ~s_v & ~hazard;

  always_comb begin
    nxt            = '0;
    nxt.src        = immf ? WORD'(expand_imm(opc, imm)) : rs_op;
    nxt.dest       = rd_op;
    nxt.wb         = wb_required(opc);
    nxt.wb_rd_name = rd;
    nxt.dopc       = decode_ope(opc);
    nxt.opc        = opc;
    nxt.origaddr   = bus.origaddr_i;
    nxt.cc         = rd[W_CC-1:0];
    nxt.data_addr  = rs_op[ADDR-1:0] + {{(ADDR-W_IMM){imm[W_IMM-1]}}, imm};
  end

  // stall_o looks only at S.v and the local hazard, never at stall_i.
  assign bus.stall_o      = bus.v_i & (s_v | hazard);
  assign bus.rd_reserve_o = accept & nxt.wb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h      <= '0;
      s      <= '0;
      h_v    <= 1'b0;
      s_v    <= 1'b0;
      hz_cnt <= '0;
    end else begin
      if (!bus.stall_i) begin
        if (s_v) begin
          h   <= s;
          h_v <= 1'b1;
          s_v <= 1'b0;
        end else begin
          h   <= nxt;
          h_v <= accept;
        end
      end else if (!h_v) begin
        h   <= nxt;
        h_v <= accept;
      end else if (accept) begin
        s   <= nxt;
        s_v <= 1'b1;
      end

      if (bus.v_i && hazard && !s_v && (hz_cnt != {CNTW{1'b1}}))
        hz_cnt <= hz_cnt + CNTW'(1);
    end
  end

  assign bus.v_o          = h_v;
  assign bus.src_o        = h.src;
  assign bus.dest_o       = h.dest;
  assign bus.wb_o         = h.wb;
  assign bus.wb_rd_name_o = h.wb_rd_name;
  assign bus.dopc_o       = h.dopc;
  assign bus.opc_o        = h.opc;
  assign bus.origaddr_o   = h.origaddr;
  assign bus.cc_o         = h.cc;
  assign bus.data_addr_o  = h.data_addr;
  assign bus.hz_cnt_o     = hz_cnt;

endmodule

// File: tb/tb_idecode_fwd.sv
// Directed self-checking bench for idecode_fwd: reset, back-to-back flow,
// forwarding priority, hazard stalls, skid buffer ordering, decode/address
// wrap, counter saturation (CNTW=2 instance) and reset during a stall.
module tb_idecode_fwd;
  import idecode_fwd_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  idecode_fwd_if #(.CNTW(16)) bus ();
  idecode_fwd_if #(.CNTW(2))  bus2 ();

  idecode_fwd #(.CNTW(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  idecode_fwd #(.CNTW(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk(input logic [3:0] opc, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic immf,
                                     input logic [15:0] imm);
    return {opc, rd, rs, immf, 3'b000, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.v_i = 0; bus.inst_i = '0; bus.origaddr_i = '0; bus.stall_i = 0;
    bus.rd_data_i = '0; bus.rs_data_i = '0; bus.rd_reserved_i = 0; bus.rs_reserved_i = 0;
    bus.fwd_v_i = '0; bus.fwd_name_i = '0; bus.fwd_data_i = '0;
    bus2.v_i = 0; bus2.inst_i = '0; bus2.origaddr_i = '0; bus2.stall_i = 0;
    bus2.rd_data_i = '0; bus2.rs_data_i = '0; bus2.rd_reserved_i = 0; bus2.rs_reserved_i = 0;
    bus2.fwd_v_i = '0; bus2.fwd_name_i = '0; bus2.fwd_data_i = '0;
  endtask

  task automatic test_reset();
    rst = 0;
    #3;
    total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o got=%b exp=0", bus.v_o); end
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall_o got=%b exp=0", bus.stall_o); end
    total++; if (bus.hz_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_hz got=%0d exp=0", bus.hz_cnt_o); end
    total++; if (bus.rd_reserve_o !== 1'b0) begin bad++; $display("FAIL reset_rd_reserve got=%b exp=0", bus.rd_reserve_o); end
    @(negedge clk);
    rst = 1;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus.v_i = 1;
      bus.inst_i = mk(OPC_ADD, 4'(i + 1), 4'(i + 5), 1'b0, 16'h0);
      bus.origaddr_i = 32'(4 * i);
      bus.rs_data_i = 32'h100 + 32'(i);
      bus.rd_data_i = 32'h200 + 32'(i);
      @(negedge clk);
      total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL b2b_stall[%0d] got=%b exp=0", i, bus.stall_o); end
      total++; if (bus.rd_reserve_o !== 1'b1) begin bad++; $display("FAIL b2b_rd_reserve[%0d] got=%b exp=1", i, bus.rd_reserve_o); end
      total++; if (bus.rs_name_o !== 4'(i + 5)) begin bad++; $display("FAIL b2b_rs_name[%0d] got=%0d exp=%0d", i, bus.rs_name_o, i + 5); end
      tick();
      total++; if (bus.v_o !== 1'b1) begin bad++; $display("FAIL b2b_v_o[%0d] got=%b exp=1", i, bus.v_o); end
      total++; if (bus.origaddr_o !== 32'(4 * i)) begin bad++; $display("FAIL b2b_addr[%0d] got=%0h exp=%0h", i, bus.origaddr_o, 4 * i); end
      total++; if (bus.src_o !== 32'h100 + 32'(i)) begin bad++; $display("FAIL b2b_src[%0d] got=%0h exp=%0h", i, bus.src_o, 32'h100 + i); end
      total++; if (bus.dest_o !== 32'h200 + 32'(i)) begin bad++; $display("FAIL b2b_dest[%0d] got=%0h exp=%0h", i, bus.dest_o, 32'h200 + i); end
      total++; if (bus.wb_rd_name_o !== 4'(i + 1)) begin bad++; $display("FAIL b2b_wbname[%0d] got=%0d exp=%0d", i, bus.wb_rd_name_o, i + 1); end
    end
    bus.v_i = 0;
    tick();
    total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", bus.v_o); end
  endtask

  task automatic test_forward();
    bus.v_i = 1;
    bus.inst_i = mk(OPC_ADD, 4'd1, 4'd3, 1'b0, 16'h0);
    bus.origaddr_i = 32'h20;
    bus.rs_reserved_i = 1; bus.rs_data_i = 32'hDEAD0000;
    bus.fwd_v_i = 2'b10; bus.fwd_name_i = {4'd3, 4'd0}; bus.fwd_data_i = {32'h55, 32'h0};
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL fwd1_stall got=%b exp=0", bus.stall_o); end
    tick();
    total++; if (bus.src_o !== 32'h55) begin bad++; $display("FAIL fwd1_src got=%0h exp=55", bus.src_o); end
    total++; if (bus.v_o !== 1'b1) begin bad++; $display("FAIL fwd1_v_o got=%b exp=1", bus.v_o); end

    bus.inst_i = mk(OPC_ADD, 4'd3, 4'd3, 1'b0, 16'h0);
    bus.origaddr_i = 32'h24;
    bus.rd_reserved_i = 1; bus.rd_data_i = 32'hBEEF;
    bus.fwd_v_i = 2'b11; bus.fwd_name_i = {4'd3, 4'd3}; bus.fwd_data_i = {32'h55, 32'hAA};
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL fwd0_stall got=%b exp=0", bus.stall_o); end
    total++; if (bus.rd_reserve_o !== 1'b1) begin bad++; $display("FAIL fwd0_rd_reserve got=%b exp=1", bus.rd_reserve_o); end
    tick();
    total++; if (bus.src_o !== 32'hAA) begin bad++; $display("FAIL fwd0_src got=%0h exp=aa", bus.src_o); end
    total++; if (bus.dest_o !== 32'hAA) begin bad++; $display("FAIL fwd0_dest got=%0h exp=aa", bus.dest_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_hazard();
    bus.v_i = 1;
    bus.inst_i = mk(OPC_SUB, 4'd2, 4'd4, 1'b0, 16'h0);
    bus.origaddr_i = 32'h40;
    bus.rs_reserved_i = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL hz_stall[%0d] got=%b exp=1", c, bus.stall_o); end
      total++; if (bus.rd_reserve_o !== 1'b0) begin bad++; $display("FAIL hz_rd_reserve[%0d] got=%b exp=0", c, bus.rd_reserve_o); end
      tick();
      total++; if (bus.hz_cnt_o !== 16'(c + 1)) begin bad++; $display("FAIL hz_cnt[%0d] got=%0d exp=%0d", c, bus.hz_cnt_o, c + 1); end
      total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL hz_v_o[%0d] got=%b exp=0", c, bus.v_o); end
    end
    bus.rs_reserved_i = 0; bus.rs_data_i = 32'h9;
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL hz_clear_stall got=%b exp=0", bus.stall_o); end
    total++; if (bus.rd_reserve_o !== 1'b1) begin bad++; $display("FAIL hz_clear_rd_reserve got=%b exp=1", bus.rd_reserve_o); end
    tick();
    total++; if (bus.v_o !== 1'b1) begin bad++; $display("FAIL hz_clear_v_o got=%b exp=1", bus.v_o); end
    total++; if (bus.origaddr_o !== 32'h40) begin bad++; $display("FAIL hz_clear_addr got=%0h exp=40", bus.origaddr_o); end
    total++; if (bus.hz_cnt_o !== 16'd3) begin bad++; $display("FAIL hz_clear_cnt got=%0d exp=3", bus.hz_cnt_o); end
    // Immediate form does not read rs, so a reserved rs is no hazard.
    bus.inst_i = mk(OPC_ADD, 4'd2, 4'd4, 1'b1, 16'h7);
    bus.rs_reserved_i = 1;
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL hz_immf_stall got=%b exp=0", bus.stall_o); end
    tick();
    total++; if (bus.src_o !== 32'h7) begin bad++; $display("FAIL hz_immf_src got=%0h exp=7", bus.src_o); end
    total++; if (bus.hz_cnt_o !== 16'd3) begin bad++; $display("FAIL hz_immf_cnt got=%0d exp=3", bus.hz_cnt_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_skid();
    bus.v_i = 1; bus.inst_i = mk(OPC_ADD, 4'd1, 4'd2, 1'b0, 16'h0); bus.origaddr_i = 32'h100;
    tick();
    total++; if (bus.origaddr_o !== 32'h100) begin bad++; $display("FAIL skid_a_addr got=%0h exp=100", bus.origaddr_o); end
    bus.stall_i = 1; bus.origaddr_i = 32'h104;
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL skid_b_stall got=%b exp=0", bus.stall_o); end
    total++; if (bus.rd_reserve_o !== 1'b1) begin bad++; $display("FAIL skid_b_rd_reserve got=%b exp=1", bus.rd_reserve_o); end
    tick();
    total++; if (bus.origaddr_o !== 32'h100) begin bad++; $display("FAIL skid_hold1_addr got=%0h exp=100", bus.origaddr_o); end
    bus.origaddr_i = 32'h108;
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL skid_full_stall got=%b exp=1", bus.stall_o); end
    total++; if (bus.rd_reserve_o !== 1'b0) begin bad++; $display("FAIL skid_full_rd_reserve got=%b exp=0", bus.rd_reserve_o); end
    tick();
    total++; if (bus.origaddr_o !== 32'h100) begin bad++; $display("FAIL skid_hold2_addr got=%0h exp=100", bus.origaddr_o); end
    total++; if (bus.v_o !== 1'b1) begin bad++; $display("FAIL skid_hold2_v got=%b exp=1", bus.v_o); end
    bus.stall_i = 0;
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL skid_drain_stall got=%b exp=1", bus.stall_o); end
    tick();
    total++; if (bus.origaddr_o !== 32'h104) begin bad++; $display("FAIL skid_s_addr got=%0h exp=104", bus.origaddr_o); end
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL skid_resume_stall got=%b exp=0", bus.stall_o); end
    tick();
    total++; if (bus.origaddr_o !== 32'h108) begin bad++; $display("FAIL skid_c_addr got=%0h exp=108", bus.origaddr_o); end
    bus.v_i = 0;
    tick();
    total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL skid_empty got=%b exp=0", bus.v_o); end
    total++; if (bus.hz_cnt_o !== 16'd3) begin bad++; $display("FAIL skid_cnt got=%0d exp=3", bus.hz_cnt_o); end
    // Stalled EX but empty head: entry still goes to H.
    bus.stall_i = 1; bus.v_i = 1; bus.origaddr_i = 32'h200;
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL skid_emptyh_stall got=%b exp=0", bus.stall_o); end
    tick();
    total++; if (bus.origaddr_o !== 32'h200 || bus.v_o !== 1'b1) begin bad++; $display("FAIL skid_emptyh_addr got=%0h v=%b exp=200 v=1", bus.origaddr_o, bus.v_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_decode_wrap();
    bus.v_i = 1; bus.origaddr_i = 32'h500;
    bus.inst_i = mk(OPC_LD, 4'd6, 4'd7, 1'b1, 16'h0020);
    bus.rs_data_i = 32'hFFFFFFF0;
    tick();
    total++; if (bus.data_addr_o !== 32'h10) begin bad++; $display("FAIL ld_daddr got=%0h exp=10", bus.data_addr_o); end
    total++; if (bus.src_o !== 32'h20) begin bad++; $display("FAIL ld_src got=%0h exp=20", bus.src_o); end
    total++; if (bus.dopc_o !== 3'd3 || bus.opc_o !== 4'd6) begin bad++; $display("FAIL ld_dopc got=%0d/%0d exp=3/6", bus.dopc_o, bus.opc_o); end
    total++; if (bus.wb_o !== 1'b1 || bus.cc_o !== 3'd6) begin bad++; $display("FAIL ld_wb_cc got=%b/%0d exp=1/6", bus.wb_o, bus.cc_o); end
    bus.inst_i = mk(OPC_ST, 4'd9, 4'd2, 1'b0, 16'hFFFC);
    bus.rs_data_i = 32'h1000; bus.rd_data_i = 32'h77;
    @(negedge clk);
    total++; if (bus.rd_reserve_o !== 1'b0) begin bad++; $display("FAIL st_rd_reserve got=%b exp=0", bus.rd_reserve_o); end
    tick();
    total++; if (bus.data_addr_o !== 32'hFFC) begin bad++; $display("FAIL st_daddr got=%0h exp=ffc", bus.data_addr_o); end
    total++; if (bus.wb_o !== 1'b0 || bus.dopc_o !== 3'd4) begin bad++; $display("FAIL st_wb_dopc got=%b/%0d exp=0/4", bus.wb_o, bus.dopc_o); end
    total++; if (bus.cc_o !== 3'd1) begin bad++; $display("FAIL st_cc got=%0d exp=1", bus.cc_o); end
    total++; if (bus.src_o !== 32'h1000 || bus.dest_o !== 32'h77) begin bad++; $display("FAIL st_ops got=%0h/%0h exp=1000/77", bus.src_o, bus.dest_o); end
    bus.inst_i = mk(OPC_LUI, 4'd1, 4'd0, 1'b1, 16'h1234);
    tick();
    total++; if (bus.src_o !== 32'h12340000) begin bad++; $display("FAIL lui_src got=%0h exp=12340000", bus.src_o); end
    total++; if (bus.dopc_o !== 3'd2) begin bad++; $display("FAIL lui_dopc got=%0d exp=2", bus.dopc_o); end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturate();
    int exp;
    bus2.v_i = 1;
    bus2.inst_i = mk(OPC_ADD, 4'd1, 4'd5, 1'b0, 16'h0);
    bus2.rs_reserved_i = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (bus2.stall_o !== 1'b1) begin bad++; $display("FAIL sat_stall[%0d] got=%b exp=1", c, bus2.stall_o); end
      tick();
      exp = (c + 1 > 3) ? 3 : c + 1;
      total++; if (bus2.hz_cnt_o !== 2'(exp)) begin bad++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", c, bus2.hz_cnt_o, exp); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    bus.v_i = 1; bus.inst_i = mk(OPC_ADD, 4'd1, 4'd2, 1'b0, 16'h0); bus.origaddr_i = 32'h300;
    tick();
    bus.stall_i = 1; bus.origaddr_i = 32'h304;
    tick();
    @(negedge clk);
    total++; if (bus.stall_o !== 1'b1) begin bad++; $display("FAIL rstmid_pre_stall got=%b exp=1", bus.stall_o); end
    #2 rst = 0;
    #1;
    total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL rstmid_v_o got=%b exp=0", bus.v_o); end
    total++; if (bus.hz_cnt_o !== 16'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", bus.hz_cnt_o); end
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL rstmid_stall got=%b exp=0", bus.stall_o); end
    tick();
    total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL rstmid_held got=%b exp=0", bus.v_o); end
    @(negedge clk);
    rst = 1; bus.stall_i = 0; bus.origaddr_i = 32'h400;
    #1;
    total++; if (bus.stall_o !== 1'b0) begin bad++; $display("FAIL rstmid_post_stall got=%b exp=0", bus.stall_o); end
    tick();
    total++; if (bus.v_o !== 1'b1 || bus.origaddr_o !== 32'h400) begin bad++; $display("FAIL rstmid_first got=%b/%0h exp=1/400", bus.v_o, bus.origaddr_o); end
    bus.v_i = 0;
    tick();
    total++; if (bus.v_o !== 1'b0) begin bad++; $display("FAIL rstmid_no_dup got=%b exp=0", bus.v_o); end
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_forward();
    test_hazard();
    test_skid();
    test_decode_wrap();
    test_saturate();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
